chip8_keypad_scanner: RTL

- Scans a 4x4 passive matrix keypad and debounces every key.
- Produces the 16-bit pressed-key bitmap and "newest key down" tracking consumed by the chip8 core's keyboard inputs: input_keys, newest_key_down, clear_newest_key_down.
- Sits directly upstream of chip8. Runs on the board clock; the chip8-side clear request is synchronised internally.

---
 rtl/chip8_keypad_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/chip8_keypad_scanner.sv
// 4x4 matrix keypad scanner with per-key debounce and newest-key tracking for the chip8 core.
// Columns are driven one at a time; each key is debounced over consecutive full-sweep samples.
module chip8_keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  input  logic        clear_newest_key_down,
  output logic [15:0] input_keys,
  output logic [4:0]  newest_key_down
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_SCANS - 1);
  localparam logic [4:0]       NO_KEY   = 5'd16;

  typedef enum logic [1:0] {DRIVE0, DRIVE1, DRIVE2, DRIVE3} scan_state_t;

  scan_state_t      state_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       cols_q;
  logic [3:0]       rows_s1_q, rows_s2_q;
  logic             clr_s1_q, clr_s2_q, clr_s3_q;
  logic [15:0]      stable_q, stable_d;
  logic [3:0]       cnt_q [16];
  logic [3:0]       cnt_d [16];
  logic [15:0]      keys_q;
  logic [4:0]       newest_q, newest_d;
  logic             sample;
  logic             clr_rise;
  logic [15:0]      rise;
  logic [3:0]       kidx;

  // Physical (row, column) position to CHIP-8 hex key.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hC;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hD;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hE;
      4'hC: k = 4'hA;
      4'hD: k = 4'h0;
      4'hE: k = 4'hB;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

  assign sample = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRIVE0;
      div_q   <= '0;
      cols_q  <= 4'b1110;
    end else if (sample) begin
      div_q  <= '0;
      cols_q <= {cols_q[2:0], cols_q[3]};
      case (state_q)
        DRIVE0:  state_q <= DRIVE1;
        DRIVE1:  state_q <= DRIVE2;
        DRIVE2:  state_q <= DRIVE3;
        default: state_q <= DRIVE0;
      endcase
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Only the four keys of the column being sampled are updated.
  always_comb begin
    stable_d = stable_q;
    kidx     = '0;
    for (int k = 0; k < 16; k++) cnt_d[k] = cnt_q[k];
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        kidx = key_at(2'(r), state_q);
        if (!rows_s2_q[r] == stable_q[kidx]) begin
          cnt_d[kidx] = '0;
        end else if (cnt_q[kidx] == DB_LAST) begin
          stable_d[kidx] = ~stable_q[kidx];
          cnt_d[kidx]    = '0;
        end else begin
          cnt_d[kidx] = cnt_q[kidx] + 4'd1;
        end
      end
    end
  end

  // A fresh press overrides a simultaneous clear; scanning rows high-to-low lets the lowest row win.
  always_comb begin
    rise     = stable_q & ~keys_q;
    clr_rise = clr_s2_q & ~clr_s3_q;
    newest_d = newest_q;
    if (clr_rise) newest_d = NO_KEY;
    for (int r = 3; r >= 0; r--) begin
      for (int c = 3; c >= 0; c--) begin
        if (rise[key_at(2'(r), 2'(c))]) newest_d = {1'b0, key_at(2'(r), 2'(c))};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_s1_q <= '0;
      rows_s2_q <= '0;
      clr_s1_q  <= 1'b0;
      clr_s2_q  <= 1'b0;
      clr_s3_q  <= 1'b0;
      stable_q  <= '0;
      keys_q    <= '0;
      newest_q  <= NO_KEY;
      for (int k = 0; k < 16; k++) cnt_q[k] <= '0;
    end else begin
      rows_s1_q <= rows_n;
      rows_s2_q <= rows_s1_q;
      clr_s1_q  <= clear_newest_key_down;
      clr_s2_q  <= clr_s1_q;
      clr_s3_q  <= clr_s2_q;
      stable_q  <= stable_d;
      keys_q    <= stable_q;
      newest_q  <= newest_d;
      for (int k = 0; k < 16; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign cols_n          = cols_q;
  assign input_keys      = keys_q;
  assign newest_key_down = newest_q;

endmodule
